// File: rtl/l4_seq_pkg.sv
// Shared definitions for the L4 routing sequencer:
// cell command codes, status bit positions and FSM state encoding.
package l4_seq_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_CLEAR = 2'b01,
        CMD_MARK  = 2'b10,
        CMD_STEP  = 2'b11
    } cmd_e;

    localparam int ST_TGT_N   = 0;
    localparam int ST_NO_GROW = 1;
    localparam int ST_SRC_N   = 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_MARK_S,
        S_MARK_T,
        S_EXP_ISSUE,
        S_EXP_WAIT,
        S_TR_ISSUE,
        S_TR_WAIT,
        S_DONE
    } state_e;

endpackage

// File: rtl/l4_onehot_dec.sv
// 5-bit index to one-hot decoder of parameterised width.
// Ports: i_idx (index), o_oh (one-hot, zero if index >= W).
module l4_onehot_dec #(
    parameter int W = 32
) (
    input  logic [4:0]   i_idx,
    output logic [W-1:0] o_oh
);

    always_comb begin
        o_oh = '0;
        for (int k = 0; k < W; k++) begin
            if (i_idx == 5'(k)) begin
                o_oh[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l4_route_seq.sv
// Routing sequencer: clear, mark, expand, trace/etch one route
// through the L4 cell array.
// Ports: clk/reset, req_* request handshake with coordinates,
// rsel_v/csel_v/cell_cmd/etch_enb/ret2ue/extend array controls,
// status_in reduced array status, done_* one-cycle result.
module l4_route_seq
    import l4_seq_pkg::*;
#(
    parameter int NROWS      = 32,
    parameter int NCOLS      = 32,
    parameter int STATUS_LAT = 2,
    parameter int MAX_STEPS  = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       src_row,
    input  logic [4:0]       src_col,
    input  logic [4:0]       tgt_row,
    input  logic [4:0]       tgt_col,
    output logic [NROWS-1:0] rsel_v,
    output logic [NCOLS-1:0] csel_v,
    output logic [1:0]       cell_cmd,
    output logic             etch_enb,
    output logic             ret2ue,
    output logic             extend,
    input  logic [3:0]       status_in,
    output logic             done_valid,
    output logic             done_ok,
    output logic [9:0]       done_steps
);

    state_e      r_state;
    state_e      w_next;
    logic        w_ok;
    logic [4:0]  r_src_row;
    logic [4:0]  r_src_col;
    logic [4:0]  r_tgt_row;
    logic [4:0]  r_tgt_col;
    logic [9:0]  r_step_cnt;
    logic [10:0] r_tr_cnt;
    logic [2:0]  r_wait_cnt;
    logic        w_wait_end;
    logic        w_same;
    logic        w_mark;
    logic [4:0]  w_row_idx;
    logic [4:0]  w_col_idx;
    logic [NROWS-1:0] w_row_oh;
    logic [NCOLS-1:0] w_col_oh;
    cmd_e        w_cmd;
    logic        w_unused;

    assign w_unused = status_in[3];

    // Last wait cycle: the counter is about to reach zero.
    assign w_wait_end = (r_wait_cnt == 3'd1);
    assign w_same = (r_src_row == r_tgt_row) &&
                    (r_src_col == r_tgt_col);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_ok   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next = S_CLEAR;
                end
            end
            S_CLEAR:  w_next = S_MARK_S;
            S_MARK_S: w_next = S_MARK_T;
            S_MARK_T: begin
                if (w_same) begin
                    w_next = S_DONE;
                    w_ok   = 1'b1;
                end else begin
                    w_next = S_EXP_ISSUE;
                end
            end
            S_EXP_ISSUE: w_next = S_EXP_WAIT;
            S_EXP_WAIT: begin
                if (w_wait_end) begin
                    if (!status_in[ST_TGT_N]) begin
                        w_next = S_TR_ISSUE;
                    end else if (status_in[ST_NO_GROW]) begin
                        w_next = S_DONE;
                    end else if (r_step_cnt == 10'(MAX_STEPS)) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_EXP_ISSUE;
                    end
                end
            end
            S_TR_ISSUE: w_next = S_TR_WAIT;
            S_TR_WAIT: begin
                if (w_wait_end) begin
                    if (!status_in[ST_SRC_N]) begin
                        w_next = S_DONE;
                        w_ok   = 1'b1;
                    end else if (r_tr_cnt ==
                                 {1'b0, r_step_cnt} + 11'd1) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_TR_ISSUE;
                    end
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_row  <= '0;
            r_src_col  <= '0;
            r_tgt_row  <= '0;
            r_tgt_col  <= '0;
            r_step_cnt <= '0;
            r_tr_cnt   <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (r_state == S_IDLE && req_valid) begin
                r_src_row  <= src_row;
                r_src_col  <= src_col;
                r_tgt_row  <= tgt_row;
                r_tgt_col  <= tgt_col;
                r_step_cnt <= '0;
                r_tr_cnt   <= '0;
            end
            if (r_state == S_EXP_ISSUE) begin
                if (r_step_cnt != 10'(MAX_STEPS)) begin
                    r_step_cnt <= r_step_cnt + 10'd1;
                end
            end
            if (r_state == S_TR_ISSUE) begin
                r_tr_cnt <= r_tr_cnt + 11'd1;
            end
            if (r_state == S_EXP_ISSUE ||
                r_state == S_TR_ISSUE) begin
                r_wait_cnt <= 3'(STATUS_LAT);
            end else if (r_state == S_EXP_WAIT ||
                         r_state == S_TR_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
            end
        end
    end

    // Outputs are registered from the next state so that each
    // output cycle lines up exactly with its state.
    assign w_mark = (w_next == S_MARK_S) || (w_next == S_MARK_T);
    assign w_row_idx = (w_next == S_MARK_T) ? r_tgt_row : r_src_row;
    assign w_col_idx = (w_next == S_MARK_T) ? r_tgt_col : r_src_col;

    l4_onehot_dec #(.W(NROWS)) u_row_dec (
        .i_idx (w_row_idx),
        .o_oh  (w_row_oh)
    );

    l4_onehot_dec #(.W(NCOLS)) u_col_dec (
        .i_idx (w_col_idx),
        .o_oh  (w_col_oh)
    );

    always_comb begin
        w_cmd = CMD_NOP;
        unique case (1'b1)
            (w_next == S_CLEAR):     w_cmd = CMD_CLEAR;
            w_mark:                  w_cmd = CMD_MARK;
            (w_next == S_EXP_ISSUE): w_cmd = CMD_STEP;
            (w_next == S_TR_ISSUE):  w_cmd = CMD_STEP;
            default:                 w_cmd = CMD_NOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready  <= 1'b1;
            cell_cmd   <= CMD_NOP;
            rsel_v     <= '0;
            csel_v     <= '0;
            etch_enb   <= 1'b0;
            ret2ue     <= 1'b0;
            extend     <= 1'b0;
            done_valid <= 1'b0;
            done_ok    <= 1'b0;
            done_steps <= '0;
        end else begin
            req_ready  <= (w_next == S_IDLE);
            cell_cmd   <= w_cmd;
            rsel_v     <= w_mark ? w_row_oh : '0;
            csel_v     <= w_mark ? w_col_oh : '0;
            etch_enb   <= (w_next == S_TR_ISSUE) ||
                          (w_next == S_TR_WAIT);
            ret2ue     <= (w_next == S_CLEAR);
            extend     <= (w_next == S_MARK_T);
            done_valid <= (w_next == S_DONE);
            done_ok    <= (w_next == S_DONE) && w_ok;
            done_steps <= (w_next == S_DONE) ? r_step_cnt : '0;
        end
    end

endmodule
